// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the CPU and the loader.
// A registered FSM grants one requester at a time and sequences the access and read latency.
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_grant_q, last_grant_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          grant_ldr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    grant_ldr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          // On a tie the loader wins only when the CPU had the previous grant.
          grant_ldr = ldr_req && (!cpu_req || (last_grant_q == OWN_CPU));
          owner_d   = grant_ldr;
          we_d      = grant_ldr ? ldr_we    : cpu_we;
          addr_d    = grant_ldr ? ldr_addr  : cpu_addr;
          wdata_d   = grant_ldr ? ldr_wdata : cpu_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = 2'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          if (owner_q == OWN_LDR) ldr_rdata_d = mem_rdata;
          else                    cpu_rdata_d = mem_rdata;
          cnt_d   = 2'd0;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= OWN_LDR;
      cnt_q        <= 2'd0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  // Strobes decode from state and are suppressed while reset is held.
  assign mem_en    = (state_q == ACCESS) && !rst;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == ACK) && (owner_q == OWN_CPU) && !rst;
  assign ldr_ack   = (state_q == ACK) && (owner_q == OWN_LDR) && !rst;
  assign cpu_stall = cpu_req && !cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port data memory between the CPU load/store path and a loader/debug port. The loader is used for boot-time data preload and runtime inspection. A registered FSM grants one requester at a time and sequences the memory access, including a parameterised read latency. It returns read data and a one-cycle acknowledge to the granted requester, and drives a stall to the CPU while its access is pending.

Parameters:
AW, 32, address width of all address ports.
DW, 32, data width of all data ports.
RD_LAT, 1, memory read latency in cycles, from the access cycle to the cycle mem_rdata is valid; legal range 1..3.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
cpu_req  input  1  CPU request; level-held until cpu_ack.
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
cpu_addr  input  AW  CPU address.
cpu_wdata  input  DW  CPU write data.
cpu_rdata  output  DW  CPU read data; registered.
cpu_ack  output  1  one-cycle completion pulse to the CPU.
cpu_stall  output  1  cpu_req & ~cpu_ack (combinational).
ldr_req  input  1  loader request; same protocol as cpu_req.
ldr_we  input  1  loader write enable.
ldr_addr  input  AW  loader address.
ldr_wdata  input  DW  loader write data.
ldr_rdata  output  DW  loader read data; registered.
ldr_ack  output  1  one-cycle completion pulse to the loader.
mem_en  output  1  memory access strobe.
mem_we  output  1  memory write enable.
mem_addr  output  AW  memory address.
mem_wdata  output  DW  memory write data.
mem_rdata  input  DW  memory read data.

Behaviour:
- States: IDLE, ACCESS, WAIT, ACK.
- Reset values:
  - state = IDLE.
  - All acks, mem_en and mem_we = 0.
  - mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0.
  - last_grant = LDR, so the CPU wins the first tie.
  - Wait counter = 0.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester opposite to last_grant (round-robin).
  - On grant, latch owner, we, addr and wdata, then go to ACCESS.
  - With no req high, stay in IDLE.
- ACCESS (one cycle):
  - mem_en = 1 and mem_we = latched we.
  - mem_addr and mem_wdata carry the latched values.
  - A write goes to ACK. A read loads the counter with RD_LAT and goes to WAIT.
- WAIT:
  - mem_en = 0; the counter decrements each cycle.
  - In the cycle where the counter equals 1, capture mem_rdata into the owner's rdata register at the clock edge and go to ACK.
  - WAIT therefore lasts exactly RD_LAT cycles.
- ACK (one cycle):
  - The owner's ack = 1 and the other ack = 0.
  - last_grant is updated to the owner, then the FSM returns to IDLE.
- Latency, measured from the IDLE cycle in which req is sampled at cycle t:
  - Write: ack at t+2.
  - Read: ack at t+2+RD_LAT, i.e. t+3 for RD_LAT = 1.
- Protocol:
  - A requester drops req on the edge that ends its ack cycle.
  - A req that is high in the IDLE cycle following ACK is a new transaction.
  - Deasserting req before it is sampled in IDLE means no transaction takes place.
  - Deasserting req after the grant is a protocol violation; the access still completes and ack is still issued.
- Held outputs:
  - rdata registers hold their value until the next read completes for the same requester.
  - Write transactions leave rdata unchanged.
  - mem_addr and mem_wdata hold their last latched value outside ACCESS.
  - mem_we = 0 whenever mem_en = 0.
- Fairness: with both requesters continuously requesting, grants alternate strictly and neither requester waits more than one transaction.
- The non-owner's inputs are ignored during ACCESS, WAIT and ACK; its req stays pending and is arbitrated at the next IDLE.
- Reset mid-operation:
  - Immediate return to IDLE; acks and mem_en are forced to 0 in the reset cycle.
  - A write already issued in ACCESS is not undone.
  - The pending read is dropped without an ack.
- No address decode or range check; the full AW value is passed to the memory.

Test Plan:
- Single CPU write (cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF) -> mem_en=mem_we=1 for exactly one cycle with addr 0x10 and data 0xDEADBEEF; cpu_ack pulses 2 cycles after sampling; cpu_stall=1 until the ack cycle.
- CPU read of 0x10 with RD_LAT=1, then RD_LAT=3 -> cpu_rdata=0xDEADBEEF together with cpu_ack at t+3 and t+5 respectively; ldr_rdata unchanged (0).
- cpu_req and ldr_req both high from reset with 4 back-to-back reads each -> grant order CPU, LDR, CPU, LDR, ...; each ack is delivered only to its owner; no two acks high in the same cycle.
- Loader writes 0x0..0x7 to addresses 0x0..0x1C while the CPU is idle, then the CPU reads 0x14 -> cpu_rdata=0x5.
- rst asserted during WAIT of a CPU read -> next cycle state is IDLE, cpu_ack never pulses, mem_en=0, and both rdata registers are 0; a re-issued read completes normally.
- ldr_req pulsed high for one cycle during a CPU ACCESS, then low -> no loader transaction and ldr_ack stays 0; pulsed high while IDLE -> one loader transaction is performed.
